// File: rtl/mc_defs.sv
// Shared encodings for the multicycle controller: FSM states, datapath mux selects,
// ALU operations and ARM condition codes.
package mc_defs;

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOrr = 3'b011;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register plus ARM condition evaluation; flags only update when the
// instruction's own condition passes.
module cond_unit
    import mc_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic       FlagWrite,
    output logic       CondEx
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            CondEq:  CondEx = z;
            CondNe:  CondEx = ~z;
            CondCs:  CondEx = c;
            CondCc:  CondEx = ~c;
            CondMi:  CondEx = n;
            CondPl:  CondEx = ~n;
            CondVs:  CondEx = v;
            CondVc:  CondEx = ~v;
            CondHi:  CondEx = c & ~z;
            CondLs:  CondEx = ~c | z;
            CondGe:  CondEx = (n == v);
            CondLt:  CondEx = (n != v);
            CondGt:  CondEx = ~z & (n == v);
            CondLe:  CondEx = z | (n != v);
            default: CondEx = 1'b1;  // AL, and 1111 treated as AL
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (FlagWrite && CondEx) begin
            flags_d = ALUFlags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore main FSM with instruction/ALU decode.
// Architectural write enables are gated by the condition unit and forced low in reset.
module multicycle_controller
    import mc_defs::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  State
);

    logic [3:0] state_q, state_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_is_pc;
    logic       is_cmp;
    logic       cond_ex;
    logic       flag_write;
    logic [2:0] dp_alu;
    logic       pc_write, mem_write, ir_write, reg_write;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd_is_pc     = (Instr[15:12] == 4'd15);
    assign is_cmp       = (funct[4:1] == 4'b1010);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign flag_write = ((state_q == StExecR) || (state_q == StExecI)) && funct[0];

    cond_unit u_cond_unit (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Instr[31:28]),
        .ALUFlags  (ALUFlags),
        .FlagWrite (flag_write),
        .CondEx    (cond_ex)
    );

    always_comb begin
        dp_alu = AluAdd;
        case (funct[4:1])
            4'b0100: dp_alu = AluAdd;
            4'b0010: dp_alu = AluSub;
            4'b0000: dp_alu = AluAnd;
            4'b1100: dp_alu = AluOrr;
            4'b1010: dp_alu = AluSub;
            default: dp_alu = AluAdd;
        endcase
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:   state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = funct[0] ? StMemRead : StMemWrite;
            StMemRead: state_d = StMemWb;
            StExecR,
            StExecI:   state_d = StAluWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SrcBReg;
        ALUControl = AluAdd;
        ResultSrc  = ResAluOut;
        case (state_q)
            StFetch: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
            end
            StDecode: begin
                // PC+8 is produced here so R15 reads see the ARM pipeline view.
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAlu;
            end
            StMemAdr: begin
                ALUSrcB    = SrcBImm;
                ALUControl = funct[3] ? AluAdd : AluSub;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc = ResData;
                reg_write = cond_ex;
                pc_write  = cond_ex & rd_is_pc;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = cond_ex;
            end
            StExecR, StExecI: begin
                ALUSrcB    = (state_q == StExecI) ? SrcBImm : SrcBReg;
                ALUControl = dp_alu;
            end
            StAluWb: begin
                reg_write = cond_ex & ~is_cmp;
                pc_write  = cond_ex & rd_is_pc;
            end
            StBranch: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAlu;
                pc_write  = cond_ex;
            end
            default: ;
        endcase
    end

    assign PCWrite  = pc_write & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign IRWrite  = ir_write & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign RegSrc   = {op == 2'b01, state_q == StBranch};
    assign ImmSrc   = op;
    assign State    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control word,
// which is popped and compared cycle by cycle against the controller outputs.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .State      (State)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       pcw, mw, rw, irw;
        logic       adr, srca;
        logic [1:0] srcb, rs;
        logic [2:0] alu;
        logic       m_adr, m_srca, m_srcb, m_rs, m_alu;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] nzcv_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Condition from pairs: even codes test the base, odd codes its inverse.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic b;
        case (c[3:1])
            3'd0: b = f[2];
            3'd1: b = f[1];
            3'd2: b = f[3];
            3'd3: b = f[0];
            3'd4: b = f[1] && !f[2];
            3'd5: b = (f[3] == f[0]);
            3'd6: b = !f[2] && (f[3] == f[0]);
            default: return 1'b1;
        endcase
        return c[0] ? !b : b;
    endfunction

    function automatic logic [2:0] alu_model(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 3'd1;
            4'b0000:          return 3'd2;
            4'b1100:          return 3'd3;
            default:          return 3'd0;
        endcase
    endfunction

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e.st = st; e.pcw = 0; e.mw = 0; e.rw = 0; e.irw = 0;
        e.adr = 0; e.srca = 0; e.srcb = 0; e.rs = 0; e.alu = 0;
        e.m_adr = 0; e.m_srca = 0; e.m_srcb = 0; e.m_rs = 0; e.m_alu = 0;
        return e;
    endfunction

    task automatic build(input logic [31:0] ins);
        exp_t       e;
        logic [1:0] op;
        logic [5:0] fn;
        logic       ce, rdpc;
        op   = ins[27:26];
        fn   = ins[25:20];
        ce   = cond_model(ins[31:28], nzcv_m);
        rdpc = (ins[15:12] == 4'hf);
        e = blank(4'd0); e.irw = 1; e.pcw = 1; e.adr = 0; e.m_adr = 1;
        e.srca = 1; e.m_srca = 1; e.srcb = 2; e.m_srcb = 1; e.alu = 0; e.m_alu = 1;
        e.rs = 2; e.m_rs = 1;
        exp_q.push_back(e);
        e = blank(4'd1); e.srca = 1; e.m_srca = 1; e.srcb = 2; e.m_srcb = 1;
        e.alu = 0; e.m_alu = 1; e.rs = 2; e.m_rs = 1;
        exp_q.push_back(e);
        if (op == 2'b10) begin
            e = blank(4'd9); e.pcw = ce; e.srca = 0; e.m_srca = 1; e.srcb = 1; e.m_srcb = 1;
            e.alu = 0; e.m_alu = 1; e.rs = 2; e.m_rs = 1;
            exp_q.push_back(e);
        end else if (op == 2'b01) begin
            e = blank(4'd2); e.srca = 0; e.m_srca = 1; e.srcb = 1; e.m_srcb = 1;
            e.alu = fn[3] ? 3'd0 : 3'd1; e.m_alu = 1;
            exp_q.push_back(e);
            if (fn[0]) begin
                e = blank(4'd3); e.adr = 1; e.m_adr = 1; e.rs = 0; e.m_rs = 1;
                exp_q.push_back(e);
                e = blank(4'd4); e.rs = 1; e.m_rs = 1; e.rw = ce; e.pcw = ce && rdpc;
                exp_q.push_back(e);
            end else begin
                e = blank(4'd5); e.adr = 1; e.m_adr = 1; e.rs = 0; e.m_rs = 1; e.mw = ce;
                exp_q.push_back(e);
            end
        end else if (op == 2'b00) begin
            e = blank(fn[5] ? 4'd7 : 4'd6); e.srca = 0; e.m_srca = 1;
            e.srcb = fn[5] ? 2'd1 : 2'd0; e.m_srcb = 1; e.alu = alu_model(fn[4:1]); e.m_alu = 1;
            exp_q.push_back(e);
            e = blank(4'd8); e.rs = 0; e.m_rs = 1;
            e.rw = ce && (fn[4:1] != 4'b1010); e.pcw = ce && rdpc;
            exp_q.push_back(e);
        end
    endtask

    // Starts at the negedge of a FETCH cycle; abort_at >= 0 asserts reset in that cycle.
    task automatic run(input logic [31:0] ins, input logic [3:0] flags, input int abort_at);
        exp_t e;
        int   n;
        logic upd;
        upd = (ins[27:26] == 2'b00) && ins[20] && cond_model(ins[31:28], nzcv_m);
        build(ins);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (n > 0) @(negedge clk);
            if (n == 0) begin
                Instr = ins;
                ALUFlags = flags;
            end
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_st", State, e.st);
                check("abort_en", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
                @(negedge clk);
                #1;
                check("abort_st_next", State, 4'd0);
                check("abort_en_next", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
                reset = 1'b0;
                exp_q.delete();
                nzcv_m = 4'b0000;
                return;
            end
            #1;
            check("state", State, e.st);
            check("pcwrite", PCWrite, e.pcw);
            check("memwrite", MemWrite, e.mw);
            check("regwrite", RegWrite, e.rw);
            check("irwrite", IRWrite, e.irw);
            check("regsrc", RegSrc, {ins[27:26] == 2'b01, e.st == 4'd9});
            check("immsrc", ImmSrc, ins[27:26]);
            if (e.m_adr) check("adrsrc", AdrSrc, e.adr);
            if (e.m_srca) check("alusrca", ALUSrcA, e.srca);
            if (e.m_srcb) check("alusrcb", ALUSrcB, e.srcb);
            if (e.m_alu) check("aluctl", ALUControl, e.alu);
            if (e.m_rs) check("resultsrc", ResultSrc, e.rs);
            n++;
        end
        @(negedge clk);
        if (upd) nzcv_m = flags;
    endtask

    initial begin
        reset = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        nzcv_m = 4'h0;
        #1;
        check("rst_en", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", State, 4'd0);
        check("rst_en_fetch", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
        reset = 1'b0;

        run(32'hE0802001, 4'h0, -1);  // ADD R2,R0,R1
        run(32'hE2510005, 4'h6, -1);  // SUBS R0,R1,#5 -> Z,C
        run(32'h0A000002, 4'h0, -1);  // BEQ taken
        run(32'hE2510005, 4'h0, -1);  // SUBS -> flags clear
        run(32'h0A000002, 4'h0, -1);  // BEQ not taken
        run(32'hE5912004, 4'h0, -1);  // LDR R2,[R1,#4]
        run(32'h05812000, 4'h0, -1);  // STREQ, Z=0
        run(32'hE2510005, 4'h4, -1);  // SUBS -> Z
        run(32'h05812000, 4'h0, -1);  // STREQ, Z=1
        run(32'hE5012004, 4'h0, -1);  // STR with subtracted offset
        run(32'hE0002001, 4'h0, -1);  // AND
        run(32'hE1802001, 4'h0, -1);  // ORR
        run(32'hE080F001, 4'h0, -1);  // ADD to PC
        run(32'hEC000000, 4'h0, -1);  // Op=11
        run(32'hE3510000, 4'h8, -1);  // CMP -> N
        run(32'hB0802001, 4'h0, -1);  // ADDLT taken
        run(32'hC0802001, 4'h0, -1);  // ADDGT not taken
        run(32'h0A000002, 4'h0, -1);  // BEQ, Z clear here
        run(32'hE2510005, 4'h4, -1);  // SUBS -> Z
        run(32'hE5912004, 4'h0, 3);   // LDR aborted in MEMREAD
        run(32'h0A000002, 4'h0, -1);  // BEQ must see cleared flags
        run(32'hE5912004, 4'h0, 4);   // LDR aborted in MEMWB
        run(32'hE0802001, 4'h0, -1);  // ADD completes after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle rework of our ARM-subset processor, which uses a single shared memory, an instruction register (IR) and the existing alu, regfileDB and extend blocks.
- A Moore main FSM sequences each instruction over 3–5 cycles.
- Combinational instruction and ALU decode plus registered NZCV condition logic gate every architectural write.
- The block sits between the IR/ALU flags and the datapath muxes and enables.

Parameters:
RESET_STATE, 4'd0, state encoding entered on reset (FETCH)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- Instr  input  32  IR contents: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
- ALUFlags  input  4  NZCV from alu, valid in the execute cycles
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=Result
- MemWrite  output  1  shared-memory write enable
- IRWrite  output  1  IR load enable
- RegWrite  output  1  regfileDB WE3
- RegSrc  output  2  [0]: RA1=15; [1]: RA2=Rd
- ImmSrc  output  2  extend select (= Op)
- ALUSrcA  output  1  0=A register, 1=PC
- ALUSrcB  output  2  00=WriteData register, 01=ExtImm, 10=constant 4
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- ResultSrc  output  2  00=ALUOut, 01=Data register, 10=ALUResult
- State  output  4  current FSM state (debug)

Behaviour:
States and transitions:
- FETCH(0) → DECODE(1), unconditionally.
- DECODE(1), by Op:
  - Op=01 → MEMADR(2)
  - Op=00 with Funct[5]=0 → EXECR(6)
  - Op=00 with Funct[5]=1 → EXECI(7)
  - Op=10 → BRANCH(9)
  - Op=11 → FETCH, with no writes.
- MEMADR(2) → MEMREAD(3) if Funct[0]=1, else → MEMWRITE(5).
- MEMREAD(3) → MEMWB(4) → FETCH.
- MEMWRITE(5) → FETCH.
- EXECR(6) / EXECI(7) → ALUWB(8) → FETCH.
- BRANCH(9) → FETCH.

Per-state outputs (all unlisted enables are 0):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. This computes PC+8 for R15 reads.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD when Funct[3]=1, else SUB.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=CondEx.
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl decoded from Funct[4:1]:
  - 0100 → ADD
  - 0010 → SUB
  - 0000 → AND
  - 1100 → ORR
  - 1010 (CMP) → SUB
  - any other value → ADD
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~(Funct[4:1]==1010).
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
- In MEMWB and ALUWB, when Rd=15, PCWrite=CondEx also (write-to-PC branch).

Decode outputs:
- RegSrc[0]=1 in BRANCH.
- RegSrc[1]=1 when Op=01 (STR path).
- ImmSrc=Op in every state.

Flags and condition:
- NZCV register, cleared by reset.
- Loaded from ALUFlags at the end of EXECR/EXECI when Funct[0]=1 and CondEx=1.
- CondEx is combinational from Cond and the registered NZCV, using the standard ARM table (EQ…LE, AL).
- Cond=1111 is treated as AL.

Latency (cycles):
- B: 3
- STR: 4
- data-processing: 4
- LDR: 5
- Op=11: 2

Reset:
- While reset=1, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0, regardless of state.
- On the next edge: State=FETCH and NZCV=0000.
- Reset asserted in any state (including mid-LDR or mid-STR) aborts the instruction with no write issued in that cycle.

Decomposition:
- Shared package/include `mc_defs`:
  - state encodings
  - ALUControl codes
  - ALUSrcB and ResultSrc codes
  - Cond codes
- One sub-module, `cond_unit`: owns the NZCV register, CondEx evaluation and the flag-write gating.
- Main FSM and decode stay in `multicycle_controller`.

Test Plan:
1. Reset 2 cycles, release, Instr=E0802001 (ADD R2,R0,R1) → States 0,1,6,8,0. RegWrite=1 only in ALUWB. IRWrite and PCWrite=1 in FETCH only.
2. Instr=E2510005 (SUBS R0,R1,#5), ALUFlags=0110 during EXECI → NZCV=0110 afterwards. Then Instr=0A000002 (BEQ) → State 9 with PCWrite=1.
3. NZCV=0000, Instr=0A000002 (BEQ) → BRANCH entered, PCWrite=0. Next state FETCH after exactly 3 cycles.
4. Instr=E5912004 (LDR R2,[R1,#4]) → States 0,1,2,3,4. AdrSrc=1 in 3. ResultSrc=01 and RegWrite=1 in 4. ALUControl=ADD in 2.
5. NZCV=0000, Instr=05812000 (STREQ) → MEMWRITE reached with MemWrite=0. With NZCV=0100 → MemWrite=1 for exactly one cycle.
6. Assert reset while State=3 (mid-LDR) → no RegWrite issued. State=0 and NZCV=0000 on the next edge. A later ADD completes normally.
